// File: rtl/socket_frame_packer_if.sv
// socket_frame_packer_if: stream bundle between the socket read
// controller, the frame packer and the downstream consumer.
//
// Signals:
//   i_data / i_dv      captured FIFO word and its valid strobe
//   o_data / o_valid   output beat and its valid
//   i_ready            downstream ready; a beat moves on o_valid & i_ready
//   o_last             final data beat of a frame
//   o_ovf / i_clr_ovf  sticky drop flag and its synchronous clear
// Modports: master = packer side, slave = driver/consumer side.

interface socket_frame_packer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_dv;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic                  o_ovf;
  logic                  i_clr_ovf;

  modport master (
    input  i_data,
    input  i_dv,
    input  i_ready,
    input  i_clr_ovf,
    output o_data,
    output o_valid,
    output o_last,
    output o_ovf
  );

  modport slave (
    output i_data,
    output i_dv,
    output i_ready,
    output i_clr_ovf,
    input  o_data,
    input  o_valid,
    input  o_last,
    input  o_ovf
  );
endinterface

// File: rtl/socket_frame_packer.sv
// socket_frame_packer: groups captured FIFO bursts into frames of
// FRAME_LEN words and replays them on a valid/ready stream.
//
// A two-bank ping-pong buffer lets capture of the next burst overlap
// draining of the previous frame. Words arriving while the write bank
// is still full are dropped and flagged on the sticky o_ovf.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   bus (master)     i_data/i_dv in, o_data/o_valid/o_last out,
//                    i_ready in, o_ovf out, i_clr_ovf in
//
// Option: define SOCKET_FRAME_PACKER_HDR_EN to prefix each frame with
// a header beat carrying a wrapping sequence number.

module socket_frame_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  socket_frame_packer_if.master bus
);

  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    SEND
  } state_t;

`ifdef SOCKET_FRAME_PACKER_HDR_EN
  localparam state_t FIRST = HEAD;
`else
  localparam state_t FIRST = SEND;
`endif

  state_t state;
  state_t state_n;

  logic [DATA_WIDTH-1:0] mem [2][FRAME_LEN];

  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          ovf;

  logic cap_en;
  logic cap_done;
  logic drop;
  logic fire;
  logic data_fire;
  logic last_fire;
  logic rd_ready;
  logic nx_ready;

  logic [DATA_WIDTH-1:0] beat;
  logic [DATA_WIDTH-1:0] data;

`ifdef SOCKET_FRAME_PACKER_HDR_EN
  logic [DATA_WIDTH-1:0] seq;
`endif

  // Capture side. Mid-frame the write bank is never full, so drops
  // can only land on frame boundaries.
  always_comb begin
    cap_en   = bus.i_dv && !full[wr_bank];
    drop     = bus.i_dv && full[wr_bank];
    cap_done = cap_en && (wr_idx == LAST_IDX);
  end

  // Drain side. A frame completing this edge counts as ready so
  // o_valid rises right after the last word lands, and so
  // back-to-back frames leave no bubble.
  always_comb begin
    fire      = (state != IDLE) && bus.i_ready;
    data_fire = fire && (state == SEND);
    last_fire = data_fire && (rd_idx == LAST_IDX);
    rd_ready  = full[rd_bank]
             || (cap_done && (wr_bank == rd_bank));
    nx_ready  = full[~rd_bank]
             || (cap_done && (wr_bank != rd_bank));
  end

  always_comb begin
    full_n = full;
    if (cap_done)  full_n[wr_bank] = 1'b1;
    if (last_fire) full_n[rd_bank] = 1'b0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (rd_ready) state_n = FIRST;
      end
      HEAD: begin
        if (fire) state_n = SEND;
      end
      SEND: begin
        if (last_fire) state_n = nx_ready ? FIRST : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      full <= full_n;
      if (cap_en) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (data_fire) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx  <= rd_idx + 1'b1;
        end
      end
    end
  end

  // Set wins over clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           ovf <= 1'b0;
    else if (drop)          ovf <= 1'b1;
    else if (bus.i_clr_ovf) ovf <= 1'b0;
  end

`ifdef SOCKET_FRAME_PACKER_HDR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       seq <= '0;
    else if (last_fire) seq <= seq + 1'b1;
  end
`endif

  // Payload storage needs no reset: it is only observed through
  // o_data while the owning bank is marked full.
  always_ff @(posedge i_clk) begin
    if (cap_en) mem[wr_bank][wr_idx[AW-1:0]] <= bus.i_data;
  end

  always_comb begin
    beat = mem[rd_bank][rd_idx[AW-1:0]];
    data = '0;
    unique case (state)
      IDLE: data = '0;
`ifdef SOCKET_FRAME_PACKER_HDR_EN
      HEAD: data = seq;
`else
      HEAD: data = '0;
`endif
      SEND: data = beat;
      default: data = '0;
    endcase
  end

  assign bus.o_data  = data;
  assign bus.o_valid = (state != IDLE);
  assign bus.o_last  = (state == SEND) && (rd_idx == LAST_IDX);
  assign bus.o_ovf   = ovf;

endmodule
